mmul_ctrl: RTL and testbench

Job sequencer for the `mmul` matrix-vector engine. It accepts a start command and a single load stream, and distributes that stream into the engine's B FIFO and M per-row A FIFOs. It then clears and fires the engine, waits out the engine's fill/drain latency, and holds the results valid until the host acknowledges them. The block sits between the host/DMA stream and one `mmul` instance plus its FIFOs.

---
 rtl/mmul_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_mmul_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmul_ctrl.sv
// mmul_ctrl: job sequencer for the mmul matrix-vector engine.
// Takes one load stream (N B elements, then M rows of N A elements),
// scatters it into the engine FIFOs, pulses clear/start, waits out the
// engine latency and holds results valid until the host acknowledges.
// Optional load-stall watchdog: define MMUL_CTRL_TIMEOUT_EN.
module mmul_ctrl #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned N            = 8,
  parameter int unsigned M            = 8,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  input  logic                  i_ld_valid,
  output logic                  o_ld_ready,
  input  logic [DATA_WIDTH-1:0] i_ld_data,
  output logic                  o_b_wren,
  output logic [DATA_WIDTH-1:0] o_b_wdata,
  output logic [M-1:0]          o_a_wren,
  output logic [DATA_WIDTH-1:0] o_a_wdata,
  output logic                  o_mm_clr,
  output logic                  o_mm_en,
  output logic                  o_res_valid,
  input  logic                  i_res_ack
);

  localparam int unsigned ELEM_W  = $clog2(N) + 1;
  localparam int unsigned ROW_W   = $clog2(M) + 1;
  localparam int unsigned RUN_LEN = N + M + DRAIN_CYCLES;
  localparam int unsigned RUN_W   = $clog2(RUN_LEN) + 1;

  localparam logic [ELEM_W-1:0] ELEM_LAST = ELEM_W'(N - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(M - 1);
  localparam logic [RUN_W-1:0]  RUN_LOAD  = RUN_W'(RUN_LEN);

  // Configurations the counters cannot represent are rejected at elaboration.
  if (N < 1 || M < 1 || TIMEOUT < 1) begin : g_bad_cfg
    $error("mmul_ctrl: N, M and TIMEOUT must all be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD_B,
    S_LOAD_A,
    S_RUN,
    S_HOLD
  } state_t;

  state_t            state, state_n;
  logic [ELEM_W-1:0] elem_cnt, elem_cnt_n;
  logic [ROW_W-1:0]  row_cnt, row_cnt_n;
  logic [RUN_W-1:0]  run_cnt, run_cnt_n;

  logic xfer_c;
  logic loading_c;
  logic elem_last_c;
  logic row_last_c;
  logic abort_c;

  // o_ld_ready mirrors the LOAD states, so this is the stream handshake.
  assign xfer_c      = i_ld_valid && o_ld_ready;
  assign loading_c   = (state == S_LOAD_B) || (state == S_LOAD_A);
  assign elem_last_c = (elem_cnt == ELEM_LAST);
  assign row_last_c  = (row_cnt == ROW_LAST);

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_n;
  end

  // Next-state and counter update logic.
  always_comb begin
    state_n    = state;
    elem_cnt_n = elem_cnt;
    row_cnt_n  = row_cnt;
    run_cnt_n  = run_cnt;
    case (state)
      S_IDLE: begin
        if (i_start) state_n = S_CLEAR;
      end
      S_CLEAR: begin
        elem_cnt_n = '0;
        row_cnt_n  = '0;
        state_n    = S_LOAD_B;
      end
      S_LOAD_B: begin
        if (xfer_c) begin
          if (elem_last_c) begin
            elem_cnt_n = '0;
            state_n    = S_LOAD_A;
          end else begin
            elem_cnt_n = elem_cnt + ELEM_W'(1);
          end
        end
      end
      S_LOAD_A: begin
        if (xfer_c) begin
          if (elem_last_c) begin
            elem_cnt_n = '0;
            if (row_last_c) begin
              row_cnt_n = '0;
              run_cnt_n = RUN_LOAD;
              state_n   = S_RUN;
            end else begin
              row_cnt_n = row_cnt + ROW_W'(1);
            end
          end else begin
            elem_cnt_n = elem_cnt + ELEM_W'(1);
          end
        end
      end
      S_RUN: begin
        if (run_cnt == '0) state_n = S_HOLD;
        else               run_cnt_n = run_cnt - RUN_W'(1);
      end
      S_HOLD: begin
        if (i_res_ack) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    if (abort_c) begin
      state_n    = S_IDLE;
      elem_cnt_n = '0;
      row_cnt_n  = '0;
    end
  end

  // Counters and registered outputs, decoded from the upcoming state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      elem_cnt    <= '0;
      row_cnt     <= '0;
      run_cnt     <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_ld_ready  <= 1'b0;
      o_b_wren    <= 1'b0;
      o_b_wdata   <= '0;
      o_a_wren    <= '0;
      o_a_wdata   <= '0;
      o_mm_clr    <= 1'b0;
      o_mm_en     <= 1'b0;
      o_res_valid <= 1'b0;
    end else begin
      elem_cnt    <= elem_cnt_n;
      row_cnt     <= row_cnt_n;
      run_cnt     <= run_cnt_n;
      o_busy      <= (state_n != S_IDLE);
      o_done      <= (state_n == S_HOLD) && (state != S_HOLD);
      o_ld_ready  <= (state_n == S_LOAD_B) || (state_n == S_LOAD_A);
      o_mm_clr    <= (state_n == S_CLEAR);
      o_mm_en     <= (state_n == S_RUN) && (state != S_RUN);
      o_res_valid <= (state_n == S_HOLD);
      o_b_wren    <= xfer_c && (state == S_LOAD_B);
      o_a_wren    <= (xfer_c && (state == S_LOAD_A)) ? (M'(1) << row_cnt) : '0;
      if (xfer_c && (state == S_LOAD_B)) o_b_wdata <= i_ld_data;
      if (xfer_c && (state == S_LOAD_A)) o_a_wdata <= i_ld_data;
    end
  end

`ifdef MMUL_CTRL_TIMEOUT_EN
  localparam int unsigned STALL_W = $clog2(TIMEOUT + 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT - 1);

  logic [STALL_W-1:0] stall_cnt;

  // Abort on the TIMEOUT-th consecutive load cycle without a transfer.
  assign abort_c = loading_c && !xfer_c && (stall_cnt == STALL_LAST);

  // Stall counter and one-cycle error pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stall_cnt <= '0;
      o_err     <= 1'b0;
    end else begin
      o_err <= abort_c;
      if (loading_c && !xfer_c && !abort_c) stall_cnt <= stall_cnt + STALL_W'(1);
      else                                  stall_cnt <= '0;
    end
  end
`else
  // Without the watchdog a stalled stream is waited out indefinitely.
  assign abort_c = 1'b0;
  assign o_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mmul_ctrl.sv
// Self-checking bench for mmul_ctrl (N=M=4, DRAIN_CYCLES=4).
module tb_mmul_ctrl;

  localparam int unsigned DW      = 8;
  localparam int unsigned N       = 4;
  localparam int unsigned M       = 4;
  localparam int unsigned DRAIN   = 4;
  localparam int unsigned TMO     = 16;
  localparam int unsigned TOTAL   = N * (M + 1);
  localparam int unsigned RUN_LEN = N + M + DRAIN;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b0;
  logic          i_start = 1'b0;
  logic          i_ld_valid = 1'b0;
  logic [DW-1:0] i_ld_data = '0;
  logic          i_res_ack = 1'b0;
  logic          o_busy, o_done, o_err, o_ld_ready, o_b_wren, o_mm_clr, o_mm_en, o_res_valid;
  logic [DW-1:0] o_b_wdata, o_a_wdata;
  logic [M-1:0]  o_a_wren;

  mmul_ctrl #(
    .DATA_WIDTH(DW), .N(N), .M(M), .DRAIN_CYCLES(DRAIN), .TIMEOUT(TMO)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .o_busy(o_busy),
    .o_done(o_done), .o_err(o_err), .i_ld_valid(i_ld_valid),
    .o_ld_ready(o_ld_ready), .i_ld_data(i_ld_data), .o_b_wren(o_b_wren),
    .o_b_wdata(o_b_wdata), .o_a_wren(o_a_wren), .o_a_wdata(o_a_wdata),
    .o_mm_clr(o_mm_clr), .o_mm_en(o_mm_en), .o_res_valid(o_res_valid),
    .i_res_ack(i_res_ack)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Reference data: stream order is B[0..N-1] then A row-major.
  logic [DW-1:0] stream [TOTAL];
  int start_cyc;

  // Observed FIFO traffic and event times.
  logic [DW-1:0] b_q [$];
  logic [DW-1:0] a_q [M][$];
  int clr_cnt, clr_cyc, en_cnt, en_cyc, done_cnt, done_cyc, err_cnt;
  int wr_first, wr_last, onehot_bad;

  always @(posedge i_clk) begin
    #2;
    if (o_mm_clr) begin
      if (clr_cnt == 0) clr_cyc = cyc;
      clr_cnt++;
    end
    if (o_mm_en) begin en_cnt++; en_cyc = cyc; end
    if (o_done) begin done_cnt++; done_cyc = cyc; end
    if (o_err) err_cnt++;
    if (o_b_wren || (o_a_wren != '0)) begin
      if (wr_first < 0) wr_first = cyc;
      wr_last = cyc;
    end
    if (o_b_wren) b_q.push_back(o_b_wdata);
    if ($countones(o_a_wren) > 1) onehot_bad++;
    for (int r = 0; r < M; r++) if (o_a_wren[r]) a_q[r].push_back(o_a_wdata);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    b_q.delete();
    for (int r = 0; r < M; r++) a_q[r].delete();
    clr_cnt = 0; clr_cyc = 0; en_cnt = 0; en_cyc = 0; done_cnt = 0; done_cyc = 0;
    err_cnt = 0; wr_first = -1; wr_last = -1; onehot_bad = 0;
  endtask

  task automatic gen_stream(input bit counting);
    for (int k = 0; k < TOTAL; k++) stream[k] = counting ? DW'(k + 1) : DW'($urandom);
  endtask

  // Called at a negedge; i_start is sampled at the next posedge.
  task automatic start_job();
    clear_mon();
    start_cyc = cyc;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    chk("busy_rise", o_busy, 1);
  endtask

  // mode 0: valid held high, 1: toggled every other cycle, 2: random.
  task automatic drive_stream(input int mode, input int limit);
    int idx = 0;
    int guard = 0;
    bit v, x;
    while (idx < limit && guard < 400) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (guard % 2) == 0;
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      i_ld_valid = v;
      i_ld_data  = stream[idx];
      x = v && o_ld_ready;
      @(negedge i_clk);
      if (x) idx++;
      guard++;
    end
    i_ld_valid = 1'b0;
    chk("stream_progress", idx, limit);
  endtask

  task automatic wait_done(input bit poke_start);
    int g = 0;
    while (!o_done && g < 100) begin
      i_start = poke_start && (en_cnt > 0);
      @(negedge i_clk);
      g++;
    end
    i_start = 1'b0;
    chk("done_seen", o_done, 1);
  endtask

  task automatic hold_and_ack(input int hold, input bit poke_start, input bit start_with_ack);
    bit rv_ok = 1'b1;
    for (int k = 0; k < hold; k++) begin
      rv_ok &= o_res_valid;
      i_start = poke_start;
      @(negedge i_clk);
    end
    rv_ok &= o_res_valid;
    chk("res_valid_hold", rv_ok, 1);
    i_res_ack = 1'b1;
    i_start   = start_with_ack;
    @(negedge i_clk);
    i_res_ack = 1'b0;
    i_start   = 1'b0;
    chk("busy_after_ack", o_busy, 0);
    chk("res_valid_after_ack", o_res_valid, 0);
  endtask

  task automatic check_job(input bit best_case);
    chk("b_count", b_q.size(), N);
    for (int k = 0; k < N && k < b_q.size(); k++) chk("b_data", b_q[k], stream[k]);
    for (int r = 0; r < M; r++) begin
      chk("a_count", a_q[r].size(), N);
      for (int k = 0; k < N && k < a_q[r].size(); k++)
        chk("a_data", a_q[r][k], stream[N + r * N + k]);
    end
    chk("a_onehot", onehot_bad, 0);
    chk("clr_pulses", clr_cnt, 1);
    chk("en_pulses", en_cnt, 1);
    chk("done_pulses", done_cnt, 1);
    chk("err_pulses", err_cnt, 0);
    chk("clr_after_start", clr_cyc - start_cyc, 1);
    chk("clr_before_writes", clr_cyc < wr_first, 1);
    chk("last_write_at_en", wr_last, en_cyc);
    chk("en_to_done", done_cyc - en_cyc, RUN_LEN + 1);
    if (best_case) begin
      chk("clr_to_en", en_cyc - clr_cyc, 1 + TOTAL);
      chk("clr_to_done", done_cyc - clr_cyc, 1 + TOTAL + RUN_LEN + 1);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({o_busy, o_done, o_err, o_ld_ready, o_b_wren, o_b_wdata, o_a_wren,
                o_a_wdata, o_mm_clr, o_mm_en, o_res_valid});
  endfunction

  initial begin
    int off1 [3];
    int off2 [3];
    int stall;
    clear_mon();

    // Reset state.
    i_rst = 1'b1;
    repeat (3) @(negedge i_clk);
    chk("reset_outputs", all_outs(), 0);
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("idle_outputs", all_outs(), 0);

    // Job 1: counting stream 1..20, valid held high.
    gen_stream(1'b1);
    start_job();
    drive_stream(0, TOTAL);
    wait_done(1'b0);
    hold_and_ack(5, 1'b0, 1'b0);
    check_job(1'b1);

    // Job 2: random data, valid toggled every other cycle.
    gen_stream(1'b0);
    start_job();
    drive_stream(1, TOTAL);
    wait_done(1'b0);
    hold_and_ack(2, 1'b0, 1'b0);
    check_job(1'b0);

    // Job 3: random valid; start poked in RUN and HOLD; start with ack.
    gen_stream(1'b0);
    start_job();
    drive_stream(2, TOTAL);
    wait_done(1'b1);
    hold_and_ack(3, 1'b1, 1'b1);
    check_job(1'b0);
    repeat (5) @(negedge i_clk);
    chk("idle_after_start_ack", o_busy, 0);
    chk("no_restart_clr", clr_cnt, 1);

    // Reset in the middle of LOAD_A, then a clean job.
    gen_stream(1'b0);
    start_job();
    drive_stream(0, 10);
    chk("pre_rst_a_strobe", o_a_wren != '0, 1);
    i_rst = 1'b1;
    #1;
    chk("async_reset_outputs", all_outs(), 0);
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("post_reset_idle", all_outs(), 0);
    gen_stream(1'b0);
    start_job();
    drive_stream(0, TOTAL);
    wait_done(1'b0);
    hold_and_ack(1, 1'b0, 1'b0);
    check_job(1'b1);

    // Back-to-back jobs: second start in the first cycle busy is low.
    gen_stream(1'b0);
    start_job();
    drive_stream(0, TOTAL);
    wait_done(1'b0);
    off1[0] = clr_cyc - start_cyc; off1[1] = en_cyc - start_cyc; off1[2] = done_cyc - start_cyc;
    hold_and_ack(0, 1'b0, 1'b0);
    check_job(1'b1);
    gen_stream(1'b0);
    start_job();
    drive_stream(0, TOTAL);
    wait_done(1'b0);
    off2[0] = clr_cyc - start_cyc; off2[1] = en_cyc - start_cyc; off2[2] = done_cyc - start_cyc;
    hold_and_ack(0, 1'b0, 1'b0);
    check_job(1'b1);
    chk("b2b_clr_offset", off2[0], off1[0]);
    chk("b2b_en_offset", off2[1], off1[1]);
    chk("b2b_done_offset", off2[2], off1[2]);
    chk("b2b_done_abs", off2[2], 1 + 1 + TOTAL + RUN_LEN + 1);

`ifdef MMUL_CTRL_TIMEOUT_EN
    // Watchdog: stream stops after 6 transfers.
    gen_stream(1'b0);
    start_job();
    drive_stream(0, 6);
    stall = 0;
    while (!o_err && stall < 40) begin
      @(negedge i_clk);
      stall++;
    end
    chk("err_at_stall", stall, TMO);
    chk("busy_after_err", o_busy, 0);
    chk("no_engine_start", en_cnt, 0);
    @(negedge i_clk);
    chk("err_single_pulse", err_cnt, 1);
`else
    stall = 0;
    chk("err_tied_low", {31'd0, o_err} + 32'(stall), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
